axis_video_unpacker: RTL and testbench

//  Receive side of the 32-bit AXI4-Stream video link: tdata={8'h00,R,G,B}, tuser=SOF, tlast=EOL, tkeep=4'hF.

---
 rtl/video_pkg.sv | 28 ++
 rtl/video_coord_cnt.sv | 54 +++++
 rtl/axis_video_unpacker.sv | 169 ++++++++++++++++
 tb/tb_axis_video_unpacker.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared types and constants for the AXI4-Stream video unpacker.
package video_pkg;

    localparam int DEF_H_RES = 640;
    localparam int DEF_V_RES = 480;
    localparam int DEF_CW    = 12;

    // One unpacked pixel colour
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // SEEK: waiting for a start-of-frame beat. LOCKED: tracking frame position.
    typedef enum logic {
        SEEK   = 1'b0,
        LOCKED = 1'b1
    } unpack_state_e;

    // Bit positions inside err_pulse
    localparam int ERR_EARLY_EOL   = 0;
    localparam int ERR_LATE_EOL    = 1;
    localparam int ERR_MISSING_SOF = 2;
    localparam int ERR_KEEP        = 3;
    localparam int ERR_W           = 4;

endpackage

// File: rtl/video_coord_cnt.sv
// Pixel x/y position tracker. 'restart' makes the current beat count as (0,0);
// 'line_end' forces a line advance even before the last column.
module video_coord_cnt
    import video_pkg::*;
#(
    parameter int H_RES = DEF_H_RES,
    parameter int V_RES = DEF_V_RES,
    parameter int CW    = DEF_CW
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          step,
    input  logic          restart,
    input  logic          line_end,
    input  logic          clear,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          at_origin,
    output logic          at_eol,
    output logic          at_eof
);

    localparam logic [CW-1:0] X_LAST = CW'(H_RES - 1);
    localparam logic [CW-1:0] Y_LAST = CW'(V_RES - 1);

    logic [CW-1:0] x_q;
    logic [CW-1:0] y_q;

    // Raw origin test (before restart) identifies a frame boundary position
    assign at_origin = (x_q == '0) && (y_q == '0);
    // Position the current beat is placed at
    assign x         = restart ? '0 : x_q;
    assign y         = restart ? '0 : y_q;
    assign at_eol    = (x == X_LAST);
    // Current beat closes the frame (line ends on the last line)
    assign at_eof    = (at_eol || line_end) && (y == Y_LAST);

    // Advance position on every consumed beat; wrap lines and frames
    always_ff @(posedge aclk) begin
        if (!aresetn || clear) begin
            x_q <= '0;
            y_q <= '0;
        end else if (step) begin
            if (at_eol || line_end) begin
                x_q <= '0;
                y_q <= (y == Y_LAST) ? '0 : y + CW'(1);
            end else begin
                x_q <= x + CW'(1);
                y_q <= y;
            end
        end
    end

endmodule

// File: rtl/axis_video_unpacker.sv
// AXI4-Stream video receive side: unpacks {00,R,G,B} beats into coordinated
// pixels, locks on tuser/tlast framing and flags framing errors.
// Optional build macro VIDEO_UNPACK_ERR_CNT_EN adds a saturating error counter.
//
// Handshake: an input beat transfers when s_axis_tvalid && s_axis_tready; an
// output pixel transfers when pix_valid && pix_ready. s_axis_tready is
// !pix_valid || pix_ready, so the single output register never overflows and
// a consumed pixel can be replaced in the same cycle.
module axis_video_unpacker
    import video_pkg::*;
#(
    parameter int H_RES = DEF_H_RES,
    parameter int V_RES = DEF_V_RES,
    parameter int CW    = DEF_CW
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [31:0]      s_axis_tdata,
    input  logic [3:0]       s_axis_tkeep,
    input  logic             s_axis_tlast,
    input  logic             s_axis_tuser,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [7:0]       pix_r,
    output logic [7:0]       pix_g,
    output logic [7:0]       pix_b,
    output logic [CW-1:0]    pix_x,
    output logic [CW-1:0]    pix_y,
    output logic             pix_sof,
    output logic             pix_eol,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic             locked,
    output logic             frame_done,
    output logic [ERR_W-1:0] err_pulse,
    output logic [15:0]      err_cnt
);

    unpack_state_e    state, state_nx;
    logic             accept;
    logic             load, step, clear;
    logic [ERR_W-1:0] err_nx;
    logic             fdone_nx;
    logic             keep_bad;
    logic [CW-1:0]    cx, cy;
    logic             at_origin, at_eol, at_eof;
    rgb_t             pix_rgb;
    logic             unused_tdata_hi;

    assign unused_tdata_hi = ^s_axis_tdata[31:24];
    assign s_axis_tready   = !pix_valid || pix_ready;
    assign accept          = s_axis_tvalid && s_axis_tready;
    assign keep_bad        = (s_axis_tkeep != 4'hF);
    assign locked          = (state == LOCKED);
    assign pix_r           = pix_rgb.r;
    assign pix_g           = pix_rgb.g;
    assign pix_b           = pix_rgb.b;

    // A tuser beat is always placed at (0,0), whichever state we are in
    video_coord_cnt #(
        .H_RES (H_RES),
        .V_RES (V_RES),
        .CW    (CW)
    ) u_coord (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .step      (step),
        .restart   (s_axis_tuser),
        .line_end  (s_axis_tlast),
        .clear     (clear),
        .x         (cx),
        .y         (cy),
        .at_origin (at_origin),
        .at_eol    (at_eol),
        .at_eof    (at_eof)
    );

    // State register
    always_ff @(posedge aclk) begin
        if (!aresetn) state <= SEEK;
        else          state <= state_nx;
    end

    // Next state, beat disposition and error classification of the accepted beat
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        clear    = 1'b0;
        err_nx   = '0;
        fdone_nx = 1'b0;
        if (accept) begin
            case (state)
                SEEK: begin
                    if (s_axis_tuser) begin
                        load     = 1'b1;
                        state_nx = LOCKED;
                    end
                end
                LOCKED: begin
                    if (s_axis_tuser) begin
                        load                    = 1'b1;
                        err_nx[ERR_MISSING_SOF] = !at_origin;
                    end else if (at_origin) begin
                        // Frame should have started here: drop lock and the beat
                        clear                   = 1'b1;
                        state_nx                = SEEK;
                        err_nx[ERR_MISSING_SOF] = 1'b1;
                        err_nx[ERR_KEEP]        = keep_bad;
                    end else begin
                        load = 1'b1;
                    end
                end
                default: state_nx = SEEK;
            endcase
            if (load) begin
                step                  = 1'b1;
                err_nx[ERR_KEEP]      = keep_bad;
                err_nx[ERR_EARLY_EOL] = s_axis_tlast && !at_eol;
                err_nx[ERR_LATE_EOL]  = at_eol && !s_axis_tlast;
                fdone_nx              = at_eof;
            end
        end
    end

    // Output pixel register, status pulses
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            pix_rgb    <= '0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_sof    <= 1'b0;
            pix_eol    <= 1'b0;
            pix_valid  <= 1'b0;
            err_pulse  <= '0;
            frame_done <= 1'b0;
        end else begin
            err_pulse  <= err_nx;
            frame_done <= fdone_nx;
            if (load) begin
                pix_rgb.r <= s_axis_tdata[23:16];
                pix_rgb.g <= s_axis_tdata[15:8];
                pix_rgb.b <= s_axis_tdata[7:0];
                pix_x     <= cx;
                pix_y     <= cy;
                pix_sof   <= (cx == '0) && (cy == '0);
                pix_eol   <= s_axis_tlast || at_eol;
                pix_valid <= 1'b1;
            end else if (pix_ready) begin
                pix_valid <= 1'b0;
            end
        end
    end

`ifdef VIDEO_UNPACK_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    // Count beats carrying any error, sticking at all-ones
    always_ff @(posedge aclk) begin
        if (!aresetn)                            err_cnt_q <= '0;
        else if (|err_nx && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_axis_video_unpacker.sv
// Self-checking bench for axis_video_unpacker with a 4x2 frame geometry.
module tb_axis_video_unpacker;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int CW = 12;
    localparam int PW = 24 + 2 * CW + 2;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [31:0]   s_axis_tdata = '0;
    logic [3:0]    s_axis_tkeep = 4'hF;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tuser = 1'b0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [7:0]    pix_r, pix_g, pix_b;
    logic [CW-1:0] pix_x, pix_y;
    logic          pix_sof, pix_eol, pix_valid;
    logic          pix_ready = 1'b0;
    logic          locked, frame_done;
    logic [3:0]    err_pulse;
    logic [15:0]   err_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [PW-1:0] exp_q[$];
    bit            m_locked = 0;
    int            m_x = 0, m_y = 0, m_errcnt = 0;
    logic [3:0]    exp_err = '0;
    logic          exp_fd = 1'b0;
    int            pix_seen = 0, fd_seen = 0;
    logic [3:0]    err_seen = '0;
    int            rdy_mode = 0;

    // Clock
    always #5 aclk = ~aclk;

    axis_video_unpacker #(.H_RES(H), .V_RES(V), .CW(CW)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .pix_r         (pix_r),
        .pix_g         (pix_g),
        .pix_b         (pix_b),
        .pix_x         (pix_x),
        .pix_y         (pix_y),
        .pix_sof       (pix_sof),
        .pix_eol       (pix_eol),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .locked        (locked),
        .frame_done    (frame_done),
        .err_pulse     (err_pulse),
        .err_cnt       (err_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] pack(input logic [31:0] d, input int x, input int y,
                                           input logic sof, input logic eol);
        logic [CW-1:0] xx, yy;
        xx = CW'(x);
        yy = CW'(y);
        return {d[23:0], xx, yy, sof, eol};
    endfunction

    function automatic logic [15:0] exp_err_cnt();
`ifdef VIDEO_UNPACK_ERR_CNT_EN
        return 16'(m_errcnt);
`else
        return 16'h0000;
`endif
    endfunction

    // Behavioural model of one accepted beat: frame position as plain integers
    task automatic model_beat();
        logic [3:0] e;
        bit         use_pix, kb, eol;
        e = '0;
        use_pix = 0;
        kb = (s_axis_tkeep != 4'hF);
        if (!m_locked) begin
            if (s_axis_tuser) begin
                m_x = 0; m_y = 0; m_locked = 1; use_pix = 1;
            end
        end else if (s_axis_tuser) begin
            if (m_x != 0 || m_y != 0) e[2] = 1'b1;
            m_x = 0; m_y = 0; use_pix = 1;
        end else if (m_x == 0 && m_y == 0) begin
            e[2] = 1'b1;
            e[3] = kb;
            m_locked = 0;
        end else begin
            use_pix = 1;
        end
        if (use_pix) begin
            e[3] = kb;
            e[0] = s_axis_tlast && (m_x < H - 1);
            e[1] = (m_x == H - 1) && !s_axis_tlast;
            eol  = s_axis_tlast || (m_x == H - 1);
            exp_q.push_back(pack(s_axis_tdata, m_x, m_y, (m_x == 0 && m_y == 0), eol));
            if (eol) begin
                if (m_y == V - 1) begin
                    exp_fd = 1'b1;
                    m_y = 0;
                end else begin
                    m_y++;
                end
                m_x = 0;
            end else begin
                m_x++;
            end
        end
        exp_err = e;
        if (e != 0 && m_errcnt < 65535) m_errcnt++;
    endtask

    // Scoreboard: compare pulses, lock and consumed pixels every cycle
    always @(negedge aclk) begin
        if (!aresetn) begin
            m_locked = 0; m_x = 0; m_y = 0; m_errcnt = 0;
            exp_err = '0; exp_fd = 1'b0;
            exp_q.delete();
        end else begin
            check("err_pulse", 64'(err_pulse), 64'(exp_err));
            check("frame_done", 64'(frame_done), 64'(exp_fd));
            check("locked", 64'(locked), 64'(m_locked));
            check("err_cnt", 64'(err_cnt), 64'(exp_err_cnt()));
            check("tready", 64'(s_axis_tready), 64'(!pix_valid || pix_ready));
            check("pix_valid", 64'(pix_valid), 64'(exp_q.size() != 0));
            if (frame_done) fd_seen++;
            err_seen = err_seen | err_pulse;
            if (pix_valid && pix_ready && exp_q.size() != 0) begin
                check("pixel", 64'({pix_r, pix_g, pix_b, pix_x, pix_y, pix_sof, pix_eol}),
                      64'(exp_q.pop_front()));
                pix_seen++;
            end
            exp_err = '0;
            exp_fd  = 1'b0;
            if (s_axis_tvalid && s_axis_tready) model_beat();
        end
    end

    // Consumer ready driver: 0 = always ready, 1 = random, 2 = held by the test
    initial begin
        forever begin
            @(posedge aclk);
            #1;
            if (rdy_mode == 0)      pix_ready = 1'b1;
            else if (rdy_mode == 1) pix_ready = 1'($urandom_range(0, 1));
        end
    end

    // Present one beat (called just after a rising edge) and wait for its transfer
    task automatic send(input logic [31:0] d, input logic u, input logic l,
                        input logic [3:0] k, output int waited);
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tkeep  = k;
        s_axis_tvalid = 1'b1;
        waited = 0;
        while (1) begin
            @(negedge aclk);
            waited++;
            if (s_axis_tready) break;
            if (waited > 200) begin
                check("send_timeout", 64'(waited), 64'd0);
                break;
            end
        end
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    function automatic logic [31:0] idx_rgb(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {8'h00, b, b, b};
    endfunction

    task automatic beat(input int i, input logic u, input logic l);
        int w;
        send(idx_rgb(i), u, l, 4'hF, w);
    endtask

    task automatic send_frame(input int base);
        for (int i = 0; i < H * V; i++)
            beat(base + i, (i == 0), ((i % H) == H - 1));
    endtask

    task automatic do_reset();
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    task automatic check_reset_outputs();
        @(negedge aclk);
        check("rst_pix_valid", 64'(pix_valid), 64'd0);
        check("rst_locked", 64'(locked), 64'd0);
        check("rst_tready", 64'(s_axis_tready), 64'd1);
        check("rst_pix_bus", 64'({pix_r, pix_g, pix_b, pix_x, pix_y, pix_sof, pix_eol}), 64'd0);
        check("rst_pulses", 64'({frame_done, err_pulse}), 64'd0);
        check("rst_err_cnt", 64'(err_cnt), 64'd0);
        @(posedge aclk);
        #1;
    endtask

    initial begin
        int w, p0, f0;
        int hold_ok;
        logic [31:0] d;

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        check_reset_outputs();

        // Junk beats before a frame start are dropped without stalling
        for (int i = 0; i < 3; i++) begin
            send(idx_rgb(100 + i), 1'b0, (i == 2), 4'hF, w);
            check("seek_tready", 64'(w), 64'd1);
        end
        @(negedge aclk);
        check("seek_no_pixel", 64'(pix_valid), 64'd0);
        check("seek_unlocked", 64'(locked), 64'd0);
        @(posedge aclk);
        #1;

        // Clean frame: 8 pixels, one frame_done, no errors; lock rises with (0,0)
        p0 = pix_seen; f0 = fd_seen; err_seen = '0;
        beat(0, 1'b1, 1'b0);
        @(negedge aclk);
        check("lock_with_sof", 64'({locked, pix_valid, pix_sof, pix_x, pix_y}),
              64'({1'b1, 1'b1, 1'b1, 12'd0, 12'd0}));
        @(posedge aclk);
        #1;
        for (int i = 1; i < H * V; i++) beat(i, 1'b0, ((i % H) == H - 1));
        repeat (2) @(negedge aclk);
        check("frame_pixels", 64'(pix_seen - p0), 64'(H * V));
        check("frame_done_once", 64'(fd_seen - f0), 64'd1);
        check("frame_no_err", 64'(err_seen), 64'd0);
        @(posedge aclk);
        #1;

        // Consumer stall mid-frame: input blocked, output held stable
        p0 = pix_seen;
        beat(10, 1'b1, 1'b0);
        beat(11, 1'b0, 1'b0);
        beat(12, 1'b0, 1'b0);
        rdy_mode = 2;
        pix_ready = 1'b0;
        s_axis_tdata = idx_rgb(13); s_axis_tuser = 1'b0; s_axis_tlast = 1'b1;
        s_axis_tkeep = 4'hF; s_axis_tvalid = 1'b1;
        hold_ok = 0;
        repeat (5) begin
            @(negedge aclk);
            check("stall_tready", 64'(s_axis_tready), 64'd0);
            check("stall_hold", 64'({pix_valid, pix_r, pix_g, pix_b, pix_x, pix_y, pix_sof, pix_eol}),
                  64'({1'b1, pack(idx_rgb(12), 2, 0, 1'b0, 1'b0)}));
        end
        @(posedge aclk);
        #1;
        rdy_mode = 0;
        pix_ready = 1'b1;
        for (int i = 3; i < H * V; i++) begin
            send(idx_rgb(10 + i), 1'b0, ((i % H) == H - 1), 4'hF, w);
            if (w == 1) hold_ok++;
        end
        check("stall_resume_rate", 64'(hold_ok), 64'(H * V - 3));
        repeat (2) @(negedge aclk);
        check("stall_no_loss", 64'(pix_seen - p0), 64'(H * V));
        @(posedge aclk);
        #1;

        // Early tlast at x=2, then missing tlast at x=3
        err_seen = '0;
        beat(20, 1'b1, 1'b0);
        beat(21, 1'b0, 1'b0);
        beat(22, 1'b0, 1'b1);
        for (int i = 0; i < H; i++) beat(23 + i, 1'b0, 1'b0);
        repeat (2) @(negedge aclk);
        check("eol_errors", 64'(err_seen), 64'b0011);
        @(posedge aclk);
        #1;

        // tuser at (2,1) restarts the frame; missing tuser after frame_done unlocks
        err_seen = '0;
        for (int i = 0; i < H + 2; i++) beat(30 + i, (i == 0), (i == H - 1));
        for (int i = 0; i < H * V; i++) beat(40 + i, (i == 0), ((i % H) == H - 1));
        beat(50, 1'b0, 1'b0);
        repeat (2) @(negedge aclk);
        check("sof_errors", 64'(err_seen), 64'b0100);
        check("sof_unlocked", 64'(locked), 64'd0);
        @(posedge aclk);
        #1;

        // Three keep-error beats, then reset in mid-frame
        do_reset();
        for (int i = 0; i < H * V; i++) begin
            send(idx_rgb(60 + i), (i == 0), ((i % H) == H - 1),
                 (i == 1 || i == 2 || i == 5) ? 4'h7 : 4'hF, w);
        end
        repeat (2) @(negedge aclk);
`ifdef VIDEO_UNPACK_ERR_CNT_EN
        check("keep_err_cnt", 64'(err_cnt), 64'd3);
`else
        check("keep_err_cnt", 64'(err_cnt), 64'd0);
`endif
        @(posedge aclk);
        #1;
        beat(70, 1'b1, 1'b0);
        beat(71, 1'b0, 1'b0);
        do_reset();
        check_reset_outputs();

        // Randomized traffic against the model
        rdy_mode = 1;
        for (int n = 0; n < 400; n++) begin
            d = $urandom;
            send(d, ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0) ? 4'h3 : 4'hF, w);
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge aclk);
                #1;
            end
        end

        // Drain
        rdy_mode = 0;
        repeat (4) @(negedge aclk);
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        check("drain_pix_valid", 64'(pix_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
